// File: rtl/vga_pkg.sv
// Shared frame geometry and arbiter state type for the VGA pixel memory path.
package vga_pkg;

    localparam int unsigned WORDS_PER_FRAME = 38400;
    localparam int unsigned PIX_PER_WORD    = 8;
    localparam int unsigned PIX_W           = 4;
    localparam int unsigned WORD_W          = PIX_PER_WORD * PIX_W;

    typedef enum logic [0:0] {
        LOAD,
        READY
    } arb_state_e;

endpackage

// File: rtl/wr_fifo.sv
// Show-ahead synchronous FIFO buffering loader words ahead of the RAM write port.
// Supports simultaneous push and pop when full; flush empties it and drops any push.
module wr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rptr_q];
    assign count   = count_q;

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally
            if (do_push) begin
                wptr_d  = wptr_q + AW'(1);
                count_d = count_d + CW'(1);
            end
            if (do_pop) begin
                rptr_d  = rptr_q + AW'(1);
                count_d = count_d - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wptr_q] <= din;
        end
    end

endmodule

// File: rtl/pix_mem_arbiter.sv
// Shares one single-port pixel RAM between the frame loader (writes) and VGA scan-out
// (reads, absolute priority). Define ARB_STALL_CNT_EN to add the stall_cnt output.
module pix_mem_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned WORDS      = WORDS_PER_FRAME,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [WORD_W-1:0] rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              img_ready
`ifdef ARB_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int unsigned       CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic              last_wr_q, last_wr_d;
    logic              wr_ready_q, wr_ready_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rd_p1_q, rd_p1_d;
    logic              rd_valid_q, rd_valid_d;

    logic              fifo_push, fifo_pop, fifo_flush;
    logic              fifo_full, fifo_empty, full_next;
    logic [WORD_W-1:0] fifo_dout;
    logic [CW-1:0]     fifo_count;

    // A word offered alongside clear is dropped
    assign fifo_push  = wr_valid && wr_ready_q && !clear;
    // Leftover words are discarded when the frame completes
    assign fifo_flush = clear || last_wr_q;

    wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_wr_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (fifo_flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (wr_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        last_wr_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        fifo_pop    = 1'b0;

        if (rd_req) begin
            mem_addr_d = rd_addr;
        end else if (state_q == LOAD && !fifo_empty && !last_wr_q) begin
            fifo_pop    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = wptr_q;
            mem_wdata_d = fifo_dout;
            wptr_d      = wptr_q + ADDR_W'(1);
            last_wr_d   = (wptr_q == LAST_ADDR);
        end

        if (last_wr_q) begin
            state_d = READY;
            wptr_d  = '0;
        end

        // A write issued this cycle still reaches RAM; only the frame bookkeeping restarts
        if (clear) begin
            state_d   = LOAD;
            wptr_d    = '0;
            last_wr_d = 1'b0;
        end
    end

    always_comb begin
        if (fifo_flush) begin
            full_next = 1'b0;
        end else if (fifo_full) begin
            full_next = !(fifo_pop && !fifo_push);
        end else begin
            full_next = (fifo_count == CW'(FIFO_DEPTH - 1)) && fifo_push && !fifo_pop;
        end
        wr_ready_d = (state_d == LOAD) && !full_next;
        rd_p1_d    = rd_req;
        rd_valid_d = rd_p1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LOAD;
            wptr_q      <= '0;
            last_wr_q   <= 1'b0;
            wr_ready_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            rd_p1_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            last_wr_q   <= last_wr_d;
            wr_ready_q  <= wr_ready_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            rd_p1_q     <= rd_p1_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign wr_ready  = wr_ready_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_valid_q ? mem_rdata : '0;
    assign img_ready = (state_q == READY);

`ifdef ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clear) begin
            stall_cnt_d = '0;
        end else if (state_q == LOAD && !fifo_empty && rd_req && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    // Stall instrumentation is not built in this configuration.
`endif

endmodule

// File: tb/tb_pix_mem_arbiter.sv
// Self-checking bench for pix_mem_arbiter: small frame, RAM model, scoreboarded writes/reads.
module tb_pix_mem_arbiter;

    localparam int unsigned WORDS  = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned RAM_N  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              clear, wr_valid, wr_ready, rd_req, rd_valid, mem_we, img_ready;
    logic [31:0]       wr_data, rd_data, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] rd_addr, mem_addr;
`ifdef ARB_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #20 clk = ~clk;

    pix_mem_arbiter #(
        .WORDS      (WORDS),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .img_ready (img_ready)
`ifdef ARB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // Single-port synchronous RAM, read-first, 1-cycle read latency
    logic [31:0] ram [RAM_N];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RAM_N; i++) ram[i] <= 32'hA5A5_0000 + 32'(i);
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    // Observer: records RAM writes and read returns; expected read data is the RAM
    // content two cycles after each request
    logic [ADDR_W-1:0] obs_waddr[$];
    logic [31:0]       obs_wdata[$];
    logic [31:0]       obs_rdata[$];
    logic [31:0]       exp_rdata[$];
    int                rd_timing_err = 0;
    logic              p1_v, p2_v;
    logic [ADDR_W-1:0] p1_a, p2_a;

    always @(negedge clk) begin
        if (reset) begin
            p1_v = 1'b0;
            p2_v = 1'b0;
            p1_a = '0;
            p2_a = '0;
        end else begin
            if (mem_we === 1'b1) begin
                obs_waddr.push_back(mem_addr);
                obs_wdata.push_back(mem_wdata);
            end
            if (p2_v) begin
                exp_rdata.push_back(ram[p2_a]);
                if (rd_valid === 1'b1) obs_rdata.push_back(rd_data);
                else rd_timing_err++;
            end else if (rd_valid !== 1'b0) begin
                rd_timing_err++;
            end
            p2_v = p1_v;
            p2_a = p1_a;
            p1_v = rd_req;
            p1_a = rd_addr;
        end
    end

    // Reference model of the write stream: the n-th word accepted since the last clear
    // lands at address n, and only the first WORDS of a frame are written
    logic [ADDR_W-1:0] exp_waddr[$];
    logic [31:0]       exp_wdata[$];
    int                frame_idx = 0;

    task automatic cycle(input logic v, input logic [31:0] d, input logic rq,
                         input logic [ADDR_W-1:0] ra, input logic clr, output logic acc);
        wr_valid = v;
        wr_data  = d;
        rd_req   = rq;
        rd_addr  = ra;
        clear    = clr;
        acc = v && (wr_ready === 1'b1) && !clr;
        if (clr) begin
            frame_idx = 0;
            exp_waddr.delete();
            exp_wdata.delete();
        end
        if (acc) begin
            if (frame_idx < WORDS) begin
                exp_waddr.push_back(ADDR_W'(frame_idx));
                exp_wdata.push_back(d);
            end
            frame_idx++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear = 0; wr_valid = 0; wr_data = '0; rd_req = 0; rd_addr = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({wr_ready, mem_we, rd_valid, img_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 0000",
                     {wr_ready, mem_we, rd_valid, img_ready});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, rd_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_buses: addr %h wdata %h rdata %h required all 0",
                     mem_addr, mem_wdata, rd_data);
        end
        reset = 1'b0;
        frame_idx = 0;
        exp_waddr.delete();
        exp_wdata.delete();
        @(posedge clk);
        #1;
        n_checks++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_wr_ready: got %b required 1", wr_ready);
        end
    endtask

    task automatic test_basic_writes();
        logic acc;
        int   wb = obs_waddr.size();
        int   n_acc = 0;
        int   drops = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 32'(i + 1) * 32'h1111_1111, 1'b0, '0, 1'b0, acc);
            if (acc) n_acc++;
            if (wr_ready !== 1'b1) drops++;
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, '0, 1'b0, '0, 1'b0, acc);
            if (wr_ready !== 1'b1) drops++;
        end
        n_checks++;
        if (n_acc != 4 || drops != 0) begin
            n_fail++;
            $display("FAIL basic_ready: accepted %0d drops %0d required 4 and 0", n_acc, drops);
        end
        n_checks++;
        if (obs_waddr.size() - wb != 4) begin
            n_fail++;
            $display("FAIL basic_count: got %0d writes required 4", obs_waddr.size() - wb);
        end
        for (int i = 0; i < 4 && wb + i < obs_waddr.size(); i++) begin
            n_checks++;
            if (obs_waddr[wb+i] !== ADDR_W'(i) || obs_wdata[wb+i] !== 32'(i + 1) * 32'h1111_1111)
            begin
                n_fail++;
                $display("FAIL basic_write%0d: got %h@%0d required %h@%0d", i, obs_wdata[wb+i],
                         obs_waddr[wb+i], 32'(i + 1) * 32'h1111_1111, i);
            end
        end
    endtask

    task automatic test_read_priority();
        logic acc;
        int   wb, rb, eb, te;
        int   k = 0;
        int   we_seen = 0;
        cycle(1'b0, '0, 1'b0, '0, 1'b1, acc);
        repeat (2) cycle(1'b0, '0, 1'b0, '0, 1'b0, acc);
        wb = obs_waddr.size(); rb = obs_rdata.size(); eb = exp_rdata.size(); te = rd_timing_err;
        for (int i = 0; i < 8; i++) begin
            cycle(k < 6, 32'hB000_0000 + 32'(k), 1'b1, ADDR_W'(5 + i % 3), 1'b0, acc);
            if (acc) k++;
            if (mem_we !== 1'b0) we_seen++;
        end
        n_checks++;
        if (k != DEPTH || wr_ready !== 1'b0 || we_seen != 0) begin
            n_fail++;
            $display("FAIL prio_stall: accepted %0d wr_ready %b writes %0d required %0d 0 0",
                     k, wr_ready, we_seen, DEPTH);
        end
        for (int i = 0; i < 12; i++) begin
            cycle(k < 6, 32'hB000_0000 + 32'(k), 1'b0, '0, 1'b0, acc);
            if (acc) k++;
        end
        n_checks++;
        if (k != 6 || obs_waddr.size() - wb != exp_waddr.size()) begin
            n_fail++;
            $display("FAIL prio_writes: accepted %0d writes %0d required 6 and %0d",
                     k, obs_waddr.size() - wb, exp_waddr.size());
        end
        for (int i = 0; i < exp_waddr.size() && wb + i < obs_waddr.size(); i++) begin
            n_checks++;
            if (obs_waddr[wb+i] !== exp_waddr[i] || obs_wdata[wb+i] !== exp_wdata[i]) begin
                n_fail++;
                $display("FAIL prio_write%0d: got %h@%0d required %h@%0d", i, obs_wdata[wb+i],
                         obs_waddr[wb+i], exp_wdata[i], exp_waddr[i]);
            end
        end
        n_checks++;
        if (obs_rdata.size() - rb != 8 || exp_rdata.size() - eb != 8 || rd_timing_err != te) begin
            n_fail++;
            $display("FAIL prio_reads: got %0d returns, %0d timing errors, required 8 and 0",
                     obs_rdata.size() - rb, rd_timing_err - te);
        end
        for (int i = 0; rb + i < obs_rdata.size() && eb + i < exp_rdata.size(); i++) begin
            n_checks++;
            if (obs_rdata[rb+i] !== exp_rdata[eb+i]) begin
                n_fail++;
                $display("FAIL prio_read%0d: got %h required %h", i, obs_rdata[rb+i],
                         exp_rdata[eb+i]);
            end
        end
    endtask

    task automatic test_frame_end();
        logic acc;
        int   wb;
        int   k = 0;
        int   late = 0;
        int   last_c = -1;
        int   rise_c = -1;
        cycle(1'b0, '0, 1'b0, '0, 1'b1, acc);
        cycle(1'b0, '0, 1'b0, '0, 1'b0, acc);
        wb = obs_waddr.size();
        for (int c = 0; c < 24; c++) begin
            cycle(k < 10, $urandom, 1'b0, '0, 1'b0, acc);
            if (acc) k++;
            if (mem_we === 1'b1 && mem_addr === ADDR_W'(WORDS - 1) && last_c < 0) last_c = c;
            if (img_ready === 1'b1 && rise_c < 0) rise_c = c;
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, $urandom, 1'b0, '0, 1'b0, acc);
            if (acc) late++;
        end
        n_checks++;
        if (k < WORDS || late != 0) begin
            n_fail++;
            $display("FAIL frame_accept: accepted %0d then %0d in READY, required >=%0d then 0",
                     k, late, WORDS);
        end
        n_checks++;
        if (last_c < 0 || rise_c != last_c + 1) begin
            n_fail++;
            $display("FAIL frame_img_ready: rose at %0d last write at %0d, required one after",
                     rise_c, last_c);
        end
        n_checks++;
        if (img_ready !== 1'b1 || wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_ready_state: img_ready %b wr_ready %b required 1 0",
                     img_ready, wr_ready);
        end
        n_checks++;
        if (obs_waddr.size() - wb != WORDS) begin
            n_fail++;
            $display("FAIL frame_count: got %0d writes required %0d", obs_waddr.size() - wb, WORDS);
        end
        for (int i = 0; i < exp_waddr.size() && wb + i < obs_waddr.size(); i++) begin
            n_checks++;
            if (obs_waddr[wb+i] !== exp_waddr[i] || obs_wdata[wb+i] !== exp_wdata[i]) begin
                n_fail++;
                $display("FAIL frame_write%0d: got %h@%0d required %h@%0d", i, obs_wdata[wb+i],
                         obs_waddr[wb+i], exp_wdata[i], exp_waddr[i]);
            end
        end
    endtask

    task automatic test_clear_ready();
        logic acc;
        int   wb = obs_waddr.size();
        cycle(1'b0, '0, 1'b0, '0, 1'b1, acc);
        n_checks++;
        if (img_ready !== 1'b0 || wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_state: img_ready %b wr_ready %b required 0 1", img_ready, wr_ready);
        end
        for (int i = 0; i < 2; i++) cycle(1'b1, $urandom, 1'b0, '0, 1'b0, acc);
        repeat (6) cycle(1'b0, '0, 1'b0, '0, 1'b0, acc);
        n_checks++;
        if (obs_waddr.size() - wb != 2 || exp_waddr.size() != 2) begin
            n_fail++;
            $display("FAIL clear_count: got %0d writes required 2", obs_waddr.size() - wb);
        end
        for (int i = 0; i < exp_waddr.size() && wb + i < obs_waddr.size(); i++) begin
            n_checks++;
            if (obs_waddr[wb+i] !== exp_waddr[i] || obs_wdata[wb+i] !== exp_wdata[i]) begin
                n_fail++;
                $display("FAIL clear_write%0d: got %h@%0d required %h@%0d", i, obs_wdata[wb+i],
                         obs_waddr[wb+i], exp_wdata[i], exp_waddr[i]);
            end
        end
    endtask

    task automatic test_clear_push();
        logic acc;
        int   wb = obs_waddr.size();
        n_checks++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clrpush_ready: got %b required 1", wr_ready);
        end
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0, '0, 1'b1, acc);
        cycle(1'b1, 32'h600D_F00D, 1'b0, '0, 1'b0, acc);
        repeat (5) cycle(1'b0, '0, 1'b0, '0, 1'b0, acc);
        n_checks++;
        if (obs_waddr.size() - wb != 1) begin
            n_fail++;
            $display("FAIL clrpush_count: got %0d writes required 1", obs_waddr.size() - wb);
        end else if (obs_waddr[wb] !== '0 || obs_wdata[wb] !== 32'h600D_F00D) begin
            n_fail++;
            $display("FAIL clrpush_write: got %h@%0d required 600df00d@0", obs_wdata[wb],
                     obs_waddr[wb]);
        end
    endtask

    task automatic test_random();
        logic acc;
        int   wb, rb, eb, te;
        cycle(1'b0, '0, 1'b0, '0, 1'b1, acc);
        cycle(1'b0, '0, 1'b0, '0, 1'b0, acc);
        wb = obs_waddr.size(); rb = obs_rdata.size(); eb = exp_rdata.size(); te = rd_timing_err;
        for (int c = 0; c < 120; c++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) == 0),
                  ADDR_W'($urandom_range(0, RAM_N - 1)), 1'b0, acc);
        end
        repeat (20) cycle(1'b0, '0, 1'b0, '0, 1'b0, acc);
        n_checks++;
        if (obs_waddr.size() - wb != exp_waddr.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d writes required %0d", obs_waddr.size() - wb,
                     exp_waddr.size());
        end
        for (int i = 0; i < exp_waddr.size() && wb + i < obs_waddr.size(); i++) begin
            n_checks++;
            if (obs_waddr[wb+i] !== exp_waddr[i] || obs_wdata[wb+i] !== exp_wdata[i]) begin
                n_fail++;
                $display("FAIL rand_write%0d: got %h@%0d required %h@%0d", i, obs_wdata[wb+i],
                         obs_waddr[wb+i], exp_wdata[i], exp_waddr[i]);
            end
        end
        n_checks++;
        if (rd_timing_err != te || obs_rdata.size() - rb != exp_rdata.size() - eb) begin
            n_fail++;
            $display("FAIL rand_read_timing: %0d timing errors, %0d returns for %0d requests",
                     rd_timing_err - te, obs_rdata.size() - rb, exp_rdata.size() - eb);
        end
        for (int i = 0; rb + i < obs_rdata.size() && eb + i < exp_rdata.size(); i++) begin
            n_checks++;
            if (obs_rdata[rb+i] !== exp_rdata[eb+i]) begin
                n_fail++;
                $display("FAIL rand_read%0d: got %h required %h", i, obs_rdata[rb+i],
                         exp_rdata[eb+i]);
            end
        end
        n_checks++;
        if (img_ready !== (frame_idx >= WORDS)) begin
            n_fail++;
            $display("FAIL rand_img_ready: got %b required %b", img_ready, frame_idx >= WORDS);
        end
    endtask

`ifdef ARB_STALL_CNT_EN
    task automatic test_stall_cnt();
        logic acc;
        cycle(1'b0, '0, 1'b0, '0, 1'b1, acc);
        cycle(1'b0, '0, 1'b0, '0, 1'b0, acc);
        cycle(1'b1, 32'h5151_5151, 1'b1, '0, 1'b0, acc);
        repeat (10) cycle(1'b0, '0, 1'b1, 4'd3, 1'b0, acc);
        repeat (3) cycle(1'b0, '0, 1'b0, '0, 1'b0, acc);
        n_checks++;
        if (stall_cnt !== 16'd10) begin
            n_fail++;
            $display("FAIL stall_count: got %0d required 10", stall_cnt);
        end
        cycle(1'b0, '0, 1'b0, '0, 1'b1, acc);
        n_checks++;
        if (stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL stall_clear: got %0d required 0", stall_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_writes();
        test_read_priority();
        test_frame_end();
        test_clear_ready();
        test_clear_push();
        test_random();
`ifdef ARB_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
